pattern_match_counter: RTL

PATTERN_MATCH_COUNTER -- requirements
Module: pattern_match_counter

---
 rtl/pmc_pkg.sv | 22 ++
 rtl/pmc_counter.sv | 68 ++++++
 rtl/pattern_match_counter.sv | 88 ++++++++
 3 files changed

// File: rtl/pmc_pkg.sv
// Shared defaults and elaboration-time parameter checks for pattern_match_counter.
// Latency: n/a (constants and functions only).
// Backpressure: n/a.
package pmc_pkg;

    // Default configuration of the detector
    localparam int         PMC_PAT_W    = 4;
    localparam logic [3:0] PMC_PAT_RST  = 4'b1001;
    localparam int         PMC_CNT_W    = 3;
    localparam int         PMC_TERM_CNT = 3;

    // TERM_CNT must be reachable by a CNT_W-bit counter and must not be zero
    function automatic bit pmc_term_cnt_ok(input int term_cnt, input int cnt_w);
        return (term_cnt >= 1) && (term_cnt <= ((1 << cnt_w) - 1));
    endfunction

    // Pattern length must leave at least one bit of history and fit 16 bits
    function automatic bit pmc_pat_w_ok(input int pat_w);
        return (pat_w >= 2) && (pat_w <= 16);
    endfunction

endpackage

// File: rtl/pmc_counter.sv
// Match counter with terminal-count wrap, TERM pulse and optional one-hot view.
// Latency: COUNT/TERM update on the same edge that samples the increment.
// Backpressure: none; i_clr wins over i_inc. One-hot decode only with PMC_ONEHOT_EN.
module pmc_counter
    import pmc_pkg::*;
#(
    parameter int CNT_W    = PMC_CNT_W,
    parameter int TERM_CNT = PMC_TERM_CNT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_inc,
    input  logic                  i_clr,
    output logic                  o_term,
    output logic [CNT_W-1:0]      o_count,
    output logic [2**CNT_W-1:0]   o_cnt_oh
);

    generate
        if (!pmc_term_cnt_ok(TERM_CNT, CNT_W)) begin : g_bad_term_cnt
            $error("pmc_counter: TERM_CNT out of range for CNT_W");
        end
    endgenerate

    logic [CNT_W-1:0] r_count;
    logic             r_term;
    logic [CNT_W:0]   w_count_inc;
    logic             w_at_term;

    // One extra bit so the compare against TERM_CNT cannot alias on overflow
    assign w_count_inc = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
    assign w_at_term   = (w_count_inc == (CNT_W + 1)'(TERM_CNT));

    // Count matches; wrap to zero and pulse TERM on reaching the terminal count
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= '0;
            r_term  <= 1'b0;
        end else if (i_clr) begin
            r_count <= '0;
            r_term  <= 1'b0;
        end else if (i_inc) begin
            if (w_at_term) begin
                r_count <= '0;
                r_term  <= 1'b1;
            end else begin
                r_count <= w_count_inc[CNT_W-1:0];
                r_term  <= 1'b0;
            end
        end else begin
            r_term <= 1'b0;
        end
    end

    assign o_count = r_count;
    assign o_term  = r_term;

`ifdef PMC_ONEHOT_EN
    // One-hot view of the current count
    always_comb begin
        o_cnt_oh          = '0;
        o_cnt_oh[r_count] = 1'b1;
    end
`else
    assign o_cnt_oh = '0;
`endif

endmodule

// File: rtl/pattern_match_counter.sv
// Serial pattern detector (history compare) feeding a terminal match counter; macro PMC_ONEHOT_EN enables CNT_OH.
// Latency: MATCH/COUNT/TERM register on the edge that samples the completing bit.
// Backpressure: none; bits are taken only when IN_VLD=1, PAT_LD overrides IN_VLD.
module pattern_match_counter
    import pmc_pkg::*;
#(
    parameter int               PAT_W    = PMC_PAT_W,
    parameter logic [PAT_W-1:0] PAT_RST  = PMC_PAT_RST,
    parameter int               OVERLAP  = 1,
    parameter int               CNT_W    = PMC_CNT_W,
    parameter int               TERM_CNT = PMC_TERM_CNT
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                IN_VLD,
    input  logic                X,
    input  logic                PAT_LD,
    input  logic [PAT_W-1:0]    PAT_IN,
    input  logic                CNT_CLR,
    output logic                MATCH,
    output logic                TERM,
    output logic [CNT_W-1:0]    COUNT,
    output logic [2**CNT_W-1:0] CNT_OH
);

    generate
        if (!pmc_pat_w_ok(PAT_W)) begin : g_bad_pat_w
            $error("pattern_match_counter: PAT_W must be 2..16");
        end
    endgenerate

    // Fill counts valid bits since reset/load/non-overlap restart, saturating at PAT_W
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_NEED = FILL_W'(PAT_W - 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  r_pat;
    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_match;
    logic [PAT_W-1:0]  w_window;
    logic              w_hit;

    // Only PAT_W-1 history bits are kept; the incoming bit completes the window
    assign w_window = {r_hist, X};
    assign w_hit    = IN_VLD && !PAT_LD && (r_fill >= FILL_NEED) && (w_window == r_pat);

    // Pattern, history and fill tracking; pattern load restarts detection
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pat   <= PAT_RST;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (PAT_LD) begin
            r_pat   <= PAT_IN;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (IN_VLD) begin
            r_hist  <= w_window[PAT_W-2:0];
            r_match <= w_hit;
            if ((OVERLAP == 0) && w_hit) begin
                r_fill <= '0;
            end else if (r_fill != FILL_MAX) begin
                r_fill <= r_fill + 1'b1;
            end
        end else begin
            r_match <= 1'b0;
        end
    end

    assign MATCH = r_match;

    pmc_counter #(
        .CNT_W    (CNT_W),
        .TERM_CNT (TERM_CNT)
    ) u_counter (
        .CLK      (CLK),
        .RST      (RST),
        .i_inc    (w_hit),
        .i_clr    (CNT_CLR),
        .o_term   (TERM),
        .o_count  (COUNT),
        .o_cnt_oh (CNT_OH)
    );

endmodule
